led_seq_checker: RTL
====================

LED_SEQ_CHECKER -- requirements
Module: led_seq_checker

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 150_000_000: maximum cycles one tracked pattern may persist before a timeout error.
REQ-002 Parameter FILTER_CYCLES, default 16: consecutive stable cycles a pattern needs to be accepted (used only with GLITCH_FILTER_EN).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 led_in  input  3  monitored LED pattern {LED2,LED1,LED0}, asynchronous to clk.
REQ-006 clear  input  1  synchronous clear of cycle_count and err_count.
REQ-007 locked  output  1  high while the sequence is tracked and at least one full cycle has been seen.
REQ-008 state_out  output  3  current checker state: HUNT=0, S0=1, S1=2, S2=3, S3=4.
REQ-009 cycle_count  output  16  completed sequence cycles, saturating.
REQ-010 err_count  output  8  sequence errors, saturating.
REQ-011 err_pulse  output  1  one-cycle strobe per error.

Function
REQ-012 The legal sequence SHALL be 001 -> 010 -> 100 -> 000 -> 001, tracked by states S0..S3 respectively.
REQ-013 led_in SHALL pass through a two-flop synchronizer; an "accepted pattern" is the synchronized value, qualified per REQ-027/028.
REQ-014 HUNT: accepted 001 -> S0, with locked held low; any other pattern -> stay HUNT with no error.
REQ-015 In Sk, an accepted pattern equal to the current state's pattern SHALL cause no action.
REQ-016 In Sk, an accepted pattern equal to the next expected pattern SHALL advance to S(k+1 mod 4).
REQ-017 In Sk, any other accepted pattern, including the illegal values 011/101/110/111, SHALL be an error: go to HUNT, or directly to S0 if the pattern is 001.
REQ-018 Each S3->S0 transition SHALL increment cycle_count (saturating at 0xFFFF) and set locked.
REQ-019 locked SHALL clear on any error and on entry to HUNT.
REQ-020 A dwell counter (32-bit) SHALL count cycles in Sk since the last state entry and reset on every state change.
REQ-021 When the dwell counter reaches TIMEOUT_CYCLES-1, the block SHALL flag an error and go to HUNT. No timeout applies in HUNT.
REQ-022 Every error SHALL assert err_pulse for exactly one cycle and increment err_count (saturating at 0xFF).
REQ-023 Latency from a led_in change to state_out SHALL be 3 cycles without the filter, and 3+FILTER_CYCLES cycles with it.
REQ-024 If clear coincides with an increment, clear SHALL win (count = 0). clear SHALL NOT affect the FSM state or locked.
REQ-025 If a timeout and an accepted pattern occur in the same cycle, the accepted pattern SHALL take priority and no timeout is flagged.

Reset
REQ-026 While rst_n=0, the block SHALL force: state HUNT, state_out=0, locked=0, err_pulse=0, cycle_count=0, err_count=0, dwell and filter counters 0, synchronizer flops 000. Reset asserted mid-sequence SHALL abort tracking immediately.

Configuration
REQ-027 With macro LED_SEQ_CHECKER_GLITCH_FILTER_EN defined, a synchronized value SHALL be accepted only after it has been stable for FILTER_CYCLES consecutive cycles; shorter pulses SHALL be ignored with no error.
REQ-028 Without LED_SEQ_CHECKER_GLITCH_FILTER_EN, every synchronized value SHALL be accepted immediately; FILTER_CYCLES is unused and the filter logic is absent.

Verification (TIMEOUT_CYCLES=20, FILTER_CYCLES=4)
REQ-029 Drive 001,010,100,000,001, each held 10 cycles -> states S0..S3 then S0; cycle_count=1; locked=1 three cycles after the final 001 (plus 4 with the filter); err_count=0.
REQ-030 Lock the checker, then drive 011 from S1 -> one err_pulse, err_count=1, state HUNT, locked=0; then 001 -> S0.
REQ-031 Hold 010 for 25 cycles in S1 -> timeout error at dwell 19, state HUNT, err_count increments by 1.
REQ-032 Filter enabled: a 2-cycle 100 glitch during S0 -> no state change and no error. Filter disabled: the same glitch -> error, state HUNT.
REQ-033 Preset err_count=255 via repeated errors, add one more error -> err_count stays 255 and err_pulse still fires; assert clear in the same cycle as an S3->S0 transition -> cycle_count=0.
REQ-034 Pulse rst_n low asynchronously while in S2 -> all outputs are at reset values before the next clk edge.

Source files
------------

// File: rtl/led_seq_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | led_seq_checker: tracks the 001->010->100->000 LED sequence on a 3-bit     |
// | async input and counts completed cycles and sequence errors.               |
// | Optional glitch filter: define LED_SEQ_CHECKER_GLITCH_FILTER_EN.           |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module led_seq_checker #(
  parameter int unsigned TIMEOUT_CYCLES = 150_000_000,
  parameter int unsigned FILTER_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  led_in,
  input  logic        clear,
  output logic        locked,
  output logic [2:0]  state_out,
  output logic [15:0] cycle_count,
  output logic [7:0]  err_count,
  output logic        err_pulse
);

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    S0   = 3'd1,
    S1   = 3'd2,
    S2   = 3'd3,
    S3   = 3'd4
  } state_t;

  localparam logic [2:0]  PAT_S0      = 3'b001;
  localparam logic [2:0]  PAT_S1      = 3'b010;
  localparam logic [2:0]  PAT_S2      = 3'b100;
  localparam logic [2:0]  PAT_S3      = 3'b000;
  localparam logic [31:0] DWELL_LIMIT = 32'(TIMEOUT_CYCLES - 1);

  logic [2:0] sync_meta;
  logic [2:0] sync_q;
  logic [2:0] accepted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 3'b000;
      sync_q    <= 3'b000;
    end else begin
      sync_meta <= led_in;
      sync_q    <= sync_meta;
    end
  end

`ifdef LED_SEQ_CHECKER_GLITCH_FILTER_EN
  localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);

  logic [2:0]       cand;
  logic [2:0]       filt;
  logic [CNT_W-1:0] stable_cnt;
  logic [CNT_W-1:0] run_len;

  // Length of the current run of identical synchronized samples, saturating.
  always_comb begin
    run_len = CNT_W'(1);
    if (sync_q == cand) begin
      if (stable_cnt == CNT_W'(FILTER_CYCLES)) begin
        run_len = stable_cnt;
      end else begin
        run_len = stable_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand       <= 3'b000;
      filt       <= 3'b000;
      stable_cnt <= '0;
    end else begin
      cand       <= sync_q;
      stable_cnt <= run_len;
      if (run_len == CNT_W'(FILTER_CYCLES)) begin
        filt <= sync_q;
      end
    end
  end

  assign accepted = filt;
`else
  assign accepted = sync_q;
`endif

  function automatic logic [2:0] pat_of(input state_t s);
    logic [2:0] p;
    case (s)
      S0:      p = PAT_S0;
      S1:      p = PAT_S1;
      S2:      p = PAT_S2;
      S3:      p = PAT_S3;
      default: p = PAT_S0;
    endcase
    return p;
  endfunction

  function automatic state_t succ_of(input state_t s);
    state_t n;
    case (s)
      S0:      n = S1;
      S1:      n = S2;
      S2:      n = S3;
      S3:      n = S0;
      default: n = HUNT;
    endcase
    return n;
  endfunction

  state_t      state;
  state_t      state_nx;
  logic        seq_err;
  logic        wrap;
  logic [31:0] dwell;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HUNT;
    end else begin
      state <= state_nx;
    end
  end

  // A pattern change outranks a coincident timeout; a timeout only fires
  // while the current pattern is still being held.
  always_comb begin
    state_nx = state;
    seq_err  = 1'b0;
    wrap     = 1'b0;
    case (state)
      HUNT: begin
        if (accepted == PAT_S0) begin
          state_nx = S0;
        end
      end
      S0, S1, S2, S3: begin
        if (accepted == pat_of(state)) begin
          if (dwell == DWELL_LIMIT) begin
            seq_err  = 1'b1;
            state_nx = HUNT;
          end
        end else if (accepted == pat_of(succ_of(state))) begin
          state_nx = succ_of(state);
          wrap     = (state == S3);
        end else begin
          seq_err  = 1'b1;
          state_nx = (accepted == PAT_S0) ? S0 : HUNT;
        end
      end
      default: begin
        state_nx = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell       <= 32'd0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      cycle_count <= 16'd0;
      err_count   <= 8'd0;
    end else begin
      if ((state_nx != state) || (state == HUNT)) begin
        dwell <= 32'd0;
      end else begin
        dwell <= dwell + 32'd1;
      end

      err_pulse <= seq_err;

      if (seq_err || (state_nx == HUNT)) begin
        locked <= 1'b0;
      end else if (wrap) begin
        locked <= 1'b1;
      end

      if (clear) begin
        cycle_count <= 16'd0;
      end else if (wrap && (cycle_count != 16'hFFFF)) begin
        cycle_count <= cycle_count + 16'd1;
      end

      if (clear) begin
        err_count <= 8'd0;
      end else if (seq_err && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  assign state_out = state;

endmodule
`default_nettype wire
